prach_conv_mixer: RTL and testbench

Complex down-conversion mixer on the consumer side of the PRACH conversion NCO. It takes 256-channel time-division-multiplexed IQ samples and the NCO's cos/sin/channel/sync stream, and checks that the two streams are frame-aligned. It then multiplies each sample by the conjugate phasor and delivers rounded, scaled IQ with channel tag and sync to the downstream decimation stage.

---
 rtl/prach_pkg.sv | 47 ++++
 rtl/prach_cmult.sv | 81 ++++++++
 rtl/prach_delay.sv | 26 ++
 rtl/prach_conv_mixer.sv | 125 ++++++++++++
 tb/tb_prach_conv_mixer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prach_pkg.sv
// Shared definitions for the PRACH conversion mixer: sizes, mixer state
// encoding, sideband payload and the rounding / saturation helpers.
package prach_pkg;

  localparam int unsigned NumChn      = 256;
  localparam int unsigned DataWidth   = 16;
  localparam int unsigned NcoFracBits = 14;
  localparam int unsigned ChnWidth    = 8;
  localparam int unsigned ProdWidth   = 2 * DataWidth;
  localparam int unsigned SumWidth    = ProdWidth + 1;
  localparam int unsigned PipeDelay   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } mix_state_e;

  // Sideband travelling alongside the data pipeline
  typedef struct packed {
    logic                sync;
    logic [ChnWidth-1:0] chn;
    logic                valid;
  } side_t;

  localparam logic signed [SumWidth-1:0] RndHalf = SumWidth'(1) << (NcoFracBits - 1);
  localparam logic signed [SumWidth-1:0] SatMax  = SumWidth'((1 << (DataWidth - 1)) - 1);
  localparam logic signed [SumWidth-1:0] SatMin  = ~SatMax;

  // Round half-up, then drop the NCO fraction bits (arithmetic shift)
  function automatic logic signed [SumWidth-1:0] rnd_half_up(input logic signed [SumWidth-1:0] s);
    logic signed [SumWidth-1:0] t;
    t = s + RndHalf;
    return t >>> NcoFracBits;
  endfunction

  // Clamp to the output range; returns {clipped, value}
  function automatic logic [DataWidth:0] sat_data(input logic signed [SumWidth-1:0] r);
    if (r > SatMax) begin
      return {1'b1, DataWidth'(SatMax)};
    end else if (r < SatMin) begin
      return {1'b1, DataWidth'(SatMin)};
    end
    return {1'b0, DataWidth'(r)};
  endfunction

endpackage

// File: rtl/prach_cmult.sv
// Pipelined multiply by the conjugate phasor with half-up rounding:
//   re_o = re*cos + im*sin, im_o = im*cos - re*sin  (3 register stages)
// Macro PRACH_MIXER_SAT_EN selects saturation (and adds sat_o); otherwise
// the rounded result wraps to DataWidth bits.
// Ports: clk, rst_n, re_i/im_i (sample), cos_i/sin_i (NCO), re_o/im_o, sat_o.
module prach_cmult
  import prach_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DataWidth-1:0] re_i,
  input  logic signed [DataWidth-1:0] im_i,
  input  logic signed [DataWidth-1:0] cos_i,
  input  logic signed [DataWidth-1:0] sin_i,
  output logic signed [DataWidth-1:0] re_o,
  output logic signed [DataWidth-1:0] im_o
`ifdef PRACH_MIXER_SAT_EN
  ,
  output logic                        sat_o
`endif
);

  logic signed [ProdWidth-1:0] p_rc_q, p_is_q, p_ic_q, p_rs_q;
  logic signed [SumWidth-1:0]  sum_re_q, sum_im_q;
  logic signed [SumWidth-1:0]  rnd_re_c, rnd_im_c;
  logic signed [DataWidth-1:0] re_q, im_q;

  always_comb begin
    rnd_re_c = rnd_half_up(sum_re_q);
    rnd_im_c = rnd_half_up(sum_im_q);
  end

`ifdef PRACH_MIXER_SAT_EN
  logic [DataWidth:0] sat_re_c, sat_im_c;
  logic               sat_q;

  always_comb begin
    sat_re_c = sat_data(rnd_re_c);
    sat_im_c = sat_data(rnd_im_c);
  end
`endif

  // Multiply, add, round/reduce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_rc_q   <= '0;
      p_is_q   <= '0;
      p_ic_q   <= '0;
      p_rs_q   <= '0;
      sum_re_q <= '0;
      sum_im_q <= '0;
      re_q     <= '0;
      im_q     <= '0;
`ifdef PRACH_MIXER_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      p_rc_q   <= ProdWidth'(re_i) * ProdWidth'(cos_i);
      p_is_q   <= ProdWidth'(im_i) * ProdWidth'(sin_i);
      p_ic_q   <= ProdWidth'(im_i) * ProdWidth'(cos_i);
      p_rs_q   <= ProdWidth'(re_i) * ProdWidth'(sin_i);
      sum_re_q <= SumWidth'(p_rc_q) + SumWidth'(p_is_q);
      sum_im_q <= SumWidth'(p_ic_q) - SumWidth'(p_rs_q);
`ifdef PRACH_MIXER_SAT_EN
      re_q     <= sat_re_c[DataWidth-1:0];
      im_q     <= sat_im_c[DataWidth-1:0];
      sat_q    <= sat_re_c[DataWidth] | sat_im_c[DataWidth];
`else
      re_q     <= DataWidth'(rnd_re_c);
      im_q     <= DataWidth'(rnd_im_c);
`endif
    end
  end

  assign re_o = re_q;
  assign im_o = im_q;
`ifdef PRACH_MIXER_SAT_EN
  assign sat_o = sat_q;
`endif

endmodule

// File: rtl/prach_delay.sv
// Fixed-latency shift register with synchronous active-low clear.
// Ports: clk, rst_n, d_i (W bits in), q_o (d_i delayed DELAY cycles).
module prach_delay #(
  parameter int unsigned W     = 1,
  parameter int unsigned DELAY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DELAY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DELAY; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int unsigned k = 1; k < DELAY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign q_o = pipe_q[DELAY-1];

endmodule

// File: rtl/prach_conv_mixer.sv
// PRACH down-conversion mixer: checks frame alignment between the TDM IQ
// stream and the NCO stream, then mixes accepted samples with the conjugate
// phasor. Latency 4 cycles (input reg + 3-stage complex multiply).
// Macro PRACH_MIXER_SAT_EN enables output saturation and the sat_flag port.
// Ports: clk, rst_n (sync, active-low); din_i/din_q/din_sync (samples);
//   nco_cos/nco_sin/nco_chn/nco_sync (NCO stream); err_clr;
//   dout_i/dout_q/dout_chn/dout_sync/dout_valid; err_align (sticky); sat_flag.
module prach_conv_mixer
  import prach_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DataWidth-1:0] din_i,
  input  logic [DataWidth-1:0] din_q,
  input  logic                 din_sync,
  input  logic [DataWidth-1:0] nco_cos,
  input  logic [DataWidth-1:0] nco_sin,
  input  logic [ChnWidth-1:0]  nco_chn,
  input  logic                 nco_sync,
  input  logic                 err_clr,
  output logic [DataWidth-1:0] dout_i,
  output logic [DataWidth-1:0] dout_q,
  output logic [ChnWidth-1:0]  dout_chn,
  output logic                 dout_sync,
  output logic                 dout_valid,
  output logic                 err_align
`ifdef PRACH_MIXER_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  mix_state_e          state_q;
  logic [ChnWidth-1:0] cnt_q;
  logic                err_q;
  logic                coinc_c, err_evt_c, accept_c;
  logic [ChnWidth-1:0] chn_c;
  logic [DataWidth-1:0] s1_re_q, s1_im_q, s1_cos_q, s1_sin_q;
  side_t               side_c, side_q;

  // Alignment check; chn_c is both the expected NCO channel and the loaded count
  always_comb begin
    coinc_c   = din_sync & nco_sync;
    chn_c     = coinc_c ? '0 : cnt_q + ChnWidth'(1);
    err_evt_c = 1'b0;
    if (state_q == RUN) begin
      err_evt_c = (din_sync ^ nco_sync) | (nco_chn != chn_c);
    end
    accept_c  = (state_q == RUN) ? !err_evt_c : coinc_c;
  end

  // Lock FSM, channel counter and sticky error (error beats clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (err_evt_c) begin
        state_q <= ERR;
      end else if (accept_c) begin
        state_q <= RUN;
      end
      if (accept_c) cnt_q <= chn_c;
      if (err_evt_c) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  // Input stage; rejected samples enter as zero so dout reads 0 when invalid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_re_q  <= '0;
      s1_im_q  <= '0;
      s1_cos_q <= '0;
      s1_sin_q <= '0;
    end else begin
      s1_re_q  <= accept_c ? din_i   : '0;
      s1_im_q  <= accept_c ? din_q   : '0;
      s1_cos_q <= accept_c ? nco_cos : '0;
      s1_sin_q <= accept_c ? nco_sin : '0;
    end
  end

  always_comb begin
    side_c       = '0;
    side_c.valid = accept_c;
    side_c.chn   = accept_c ? chn_c : '0;
    side_c.sync  = accept_c & coinc_c;
  end

  prach_delay #(
    .W     ($bits(side_t)),
    .DELAY (PipeDelay)
  ) u_side_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (side_c),
    .q_o   (side_q)
  );

  prach_cmult u_cmult (
    .clk   (clk),
    .rst_n (rst_n),
    .re_i  (s1_re_q),
    .im_i  (s1_im_q),
    .cos_i (s1_cos_q),
    .sin_i (s1_sin_q),
    .re_o  (dout_i),
    .im_o  (dout_q)
`ifdef PRACH_MIXER_SAT_EN
    ,
    .sat_o (sat_flag)
`endif
  );

  assign dout_valid = side_q.valid;
  assign dout_chn   = side_q.chn;
  assign dout_sync  = side_q.sync;
  assign err_align  = err_q;

endmodule

// File: tb/tb_prach_conv_mixer.sv
// Bench for prach_conv_mixer: directed and random stimulus against a
// cycle-indexed reference model of lock/accept rules and mixer arithmetic.
module tb_prach_conv_mixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din_i, din_q, nco_cos, nco_sin;
  logic        din_sync, nco_sync, err_clr;
  logic [7:0]  nco_chn;
  logic [15:0] dout_i, dout_q;
  logic [7:0]  dout_chn;
  logic        dout_sync, dout_valid, err_align;
`ifdef PRACH_MIXER_SAT_EN
  logic        sat_flag;
`endif

  prach_conv_mixer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_i      (din_i),
    .din_q      (din_q),
    .din_sync   (din_sync),
    .nco_cos    (nco_cos),
    .nco_sin    (nco_sin),
    .nco_chn    (nco_chn),
    .nco_sync   (nco_sync),
    .err_clr    (err_clr),
    .dout_i     (dout_i),
    .dout_q     (dout_q),
    .dout_chn   (dout_chn),
    .dout_sync  (dout_sync),
    .dout_valid (dout_valid),
    .err_align  (err_align)
`ifdef PRACH_MIXER_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  localparam int Depth = 8192;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // Expected output per input cycle
  bit        ev  [Depth];
  bit        es  [Depth];
  bit [7:0]  ec  [Depth];
  bit [15:0] ei  [Depth];
  bit [15:0] eq  [Depth];
  bit        esat[Depth];

  // Model state: locked to a frame, next channel expected, sticky error
  bit m_locked = 1'b0;
  bit m_err    = 1'b0;
  int m_next   = 0;

  function automatic bit [15:0] ref_reduce(input longint p, output bit clip);
    longint r;
    r = (p + 64'sd8192) >>> 14;
    clip = 1'b0;
`ifdef PRACH_MIXER_SAT_EN
    if (r > 32767) begin
      clip = 1'b1;
      r = 32767;
    end else if (r < -32768) begin
      clip = 1'b1;
      r = -32768;
    end
`endif
    return 16'(r);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock: drive, update model, advance, compare outputs due now
  task automatic cyc(input bit rst, input bit ds, input bit ns, input bit [7:0] ch,
                     input bit [15:0] i, input bit [15:0] q, input bit [15:0] c,
                     input bit [15:0] s, input bit clr);
    int  slot;
    int  o;
    int  chn_exp;
    bit  bad;
    bit  acc;
    bit  ci;
    bit  cq;
    longint li, lq, lc, ls;
    rst_n = !rst; din_sync = ds; nco_sync = ns; nco_chn = ch;
    din_i = i; din_q = q; nco_cos = c; nco_sin = s; err_clr = clr;
    slot = cyc_n;
    ev[slot] = 1'b0; es[slot] = 1'b0; ec[slot] = '0;
    ei[slot] = '0; eq[slot] = '0; esat[slot] = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_err = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        if (slot - k >= 0) begin
          ev[slot-k] = 1'b0; es[slot-k] = 1'b0; ec[slot-k] = '0;
        end
      end
    end else begin
      chn_exp = (ds && ns) ? 0 : m_next;
      if (!m_locked) begin
        bad = 1'b0;
        acc = ds && ns;
      end else begin
        bad = (ds != ns) || (int'(ch) != chn_exp);
        acc = !bad;
      end
      if (bad) begin
        m_locked = 1'b0;
        m_err = 1'b1;
      end else if (clr) begin
        m_err = 1'b0;
      end
      if (acc) begin
        m_locked = 1'b1;
        m_next = (chn_exp + 1) % 256;
        li = longint'($signed(i)); lq = longint'($signed(q));
        lc = longint'($signed(c)); ls = longint'($signed(s));
        ev[slot] = 1'b1;
        es[slot] = ds && ns;
        ec[slot] = 8'(chn_exp);
        ei[slot] = ref_reduce(li * lc + lq * ls, ci);
        eq[slot] = ref_reduce(lq * lc - li * ls, cq);
        esat[slot] = ci | cq;
      end
    end
    @(posedge clk);
    #1;
    chk("err_align", 16'(err_align), 16'(m_err));
    o = cyc_n - 3;
    if (o >= 0) begin
      chk("dout_valid", 16'(dout_valid), 16'(ev[o]));
      chk("dout_sync", 16'(dout_sync), 16'(es[o]));
      if (ev[o]) begin
        chk("dout_chn", 16'(dout_chn), 16'(ec[o]));
        chk("dout_i", dout_i, ei[o]);
        chk("dout_q", dout_q, eq[o]);
`ifdef PRACH_MIXER_SAT_EN
        chk("sat_flag", 16'(sat_flag), 16'(esat[o]));
`endif
      end
    end
    cyc_n++;
  endtask

  // Random data with the channel the model expects next, no syncs
  task automatic run_locked(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'(m_next), 16'($urandom), 16'($urandom),
          16'($urandom), 16'($urandom), 1'b0);
    end
  endtask

  // Random data with random stray syncs/channels while unlocked
  task automatic run_unlocked(input int n);
    bit s0;
    for (int k = 0; k < n; k++) begin
      s0 = 1'($urandom_range(0, 1));
      cyc(1'b0, s0, !s0, 8'($urandom), 16'($urandom), 16'($urandom),
          16'($urandom), 16'($urandom), 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; din_sync = 1'b0; nco_sync = 1'b0; nco_chn = '0; err_clr = 1'b0;
    din_i = '0; din_q = '0; nco_cos = '0; nco_sin = '0;

    // Reset
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'd0, 16'h1234, 16'h4321, 16'h0100, 16'h0200, 1'b0);
    chk("rst_dout_i", dout_i, 16'h0);
    chk("rst_dout_q", dout_q, 16'h0);
    chk("rst_dout_chn", 16'(dout_chn), 16'h0);
    chk("rst_dout_sync", 16'(dout_sync), 16'h0);
    chk("rst_dout_valid", 16'(dout_valid), 16'h0);
`ifdef PRACH_MIXER_SAT_EN
    chk("rst_sat_flag", 16'(sat_flag), 16'h0);
`endif

    // Lone syncs do not lock
    run_unlocked(5);

    // Directed arithmetic: identity, quarter turn, rounding, overflow
    cyc(1'b0, 1'b1, 1'b1, 8'd0, 16'd16384, 16'd0, 16'd16384, 16'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd1, 16'd16384, 16'd0, 16'd0, 16'd16384, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd0, 16'd8192, 16'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd3, 16'hFFFF, 16'd0, 16'd8192, 16'd0, 1'b0);
    chk("ident_i", dout_i, 16'd16384);
    chk("ident_q", dout_q, 16'd0);
    chk("ident_valid", 16'(dout_valid), 16'd1);
    chk("ident_sync", 16'(dout_sync), 16'd1);
    chk("ident_chn", 16'(dout_chn), 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'd4, 16'd32767, 16'd32767, 16'd16384, 16'd16384, 1'b0);
    chk("quarter_i", dout_i, 16'd0);
    chk("quarter_q", dout_q, 16'hC000);
    run_locked(1);
    chk("round_pos", dout_i, 16'd1);
    run_locked(1);
    chk("round_neg", dout_i, 16'd0);
    run_locked(1);
`ifdef PRACH_MIXER_SAT_EN
    chk("sat_i", dout_i, 16'h7FFF);
    chk("sat_flag_hi", 16'(sat_flag), 16'd1);
`else
    chk("wrap_i", dout_i, 16'hFFFE);
`endif
    chk("sat_q", dout_q, 16'd0);

    // Random mixing across a frame wrap
    run_locked(300);

    // din_sync one cycle ahead of nco_sync
    cyc(1'b0, 1'b1, 1'b0, 8'(m_next), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    chk("misalign_err", 16'(err_align), 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 8'd0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    run_unlocked(2);
    chk("misalign_drop", 16'(dout_valid), 16'd0);
    run_unlocked(3);

    // Relock
    cyc(1'b0, 1'b1, 1'b1, 8'd0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    run_locked(3);
    chk("relock_valid", 16'(dout_valid), 16'd1);
    chk("relock_sync", 16'(dout_sync), 16'd1);
    chk("err_sticky", 16'(err_align), 16'd1);
    run_locked(3);

    // Channel mismatch (5 where 7 expected) together with err_clr: error wins
    cyc(1'b0, 1'b0, 1'b0, 8'd5, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    chk("chn_mismatch_err", 16'(err_align), 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'd8, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    chk("err_clr", 16'(err_align), 16'd0);
    run_unlocked(4);

    // Lock, reach cnt=100, then reset mid-frame
    cyc(1'b0, 1'b1, 1'b1, 8'd0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    run_locked(99);
    cyc(1'b1, 1'b0, 1'b0, 8'd100, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    chk("midrst_valid", 16'(dout_valid), 16'd0);
    chk("midrst_i", dout_i, 16'd0);
    chk("midrst_q", dout_q, 16'd0);
    chk("midrst_chn", 16'(dout_chn), 16'd0);
    run_unlocked(6);
    chk("midrst_idle", 16'(dout_valid), 16'd0);
    cyc(1'b0, 1'b1, 1'b1, 8'd0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    run_locked(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
